// File: rtl/can_frame_tx_pkg.sv
// Shared definitions for the CAN 2.0A frame transmitter: CRC polynomial,
// field lengths, status codes, FSM state encodings and a DLC helper.
package can_frame_tx_pkg;

  localparam logic [14:0] CAN_CRC15_POLY = 15'h4599;

  localparam int ID_LEN  = 11;
  localparam int DLC_LEN = 4;
  localparam int CRC_LEN = 15;
  localparam int EOF_LEN = 7;

  localparam logic [1:0] STATUS_OK       = 2'd0;
  localparam logic [1:0] STATUS_ARB_LOST = 2'd1;
  localparam logic [1:0] STATUS_ACK_ERR  = 2'd2;
  localparam logic [1:0] STATUS_BIT_ERR  = 2'd3;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SOF_ARB   = 3'd1;
  localparam logic [2:0] ST_CTRL_DATA = 3'd2;
  localparam logic [2:0] ST_CRC       = 3'd3;
  localparam logic [2:0] ST_CRC_DEL   = 3'd4;
  localparam logic [2:0] ST_ACK_SLOT  = 3'd5;
  localparam logic [2:0] ST_ACK_DEL   = 3'd6;
  localparam logic [2:0] ST_EOF       = 3'd7;

  // Field-counter indices of the last bit in each counted field.
  // SOF_ARB: 0=SOF, 1..11=ID, 12=RTR. CTRL_DATA: 0=IDE, 1=r0, 2..5=DLC, 6..=data.
  localparam logic [6:0] ARB_LAST = 7'(ID_LEN + 1);
  localparam logic [6:0] CTRL_HDR = 7'(2 + DLC_LEN);
  localparam logic [6:0] CRC_LAST = 7'(CRC_LEN - 1);
  localparam logic [6:0] EOF_LAST = 7'(EOF_LEN - 1);

  // Data bits carried by a frame: min(dlc,8) bytes.
  function automatic logic [6:0] data_bits(input logic [3:0] dlc);
    return (dlc > 4'd8) ? 7'd64 : {dlc, 3'b000};
  endfunction

endpackage

// File: rtl/can_frame_tx_crc15.sv
// CAN CRC15 accumulator (poly 0x4599, init 0), one bit per enabled cycle.
// Ports: clk, rstn (async low), clr (zero the register), en (shift in din),
//        din (unstuffed frame bit), crc (current remainder, MSB first on bus).
module can_crc15
  import can_frame_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [14:0] crc
);

  logic [14:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr)
      crc_d = '0;
    else if (en)
      crc_d = {crc_q[13:0], 1'b0} ^ ((din ^ crc_q[14]) ? CAN_CRC15_POLY : 15'h0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) crc_q <= '0;
    else       crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/can_frame_tx.sv
// CAN 2.0A data-frame transmitter sitting on top of a bit-timing layer.
// Ports: clk/rstn; bit_req/bit_rx (bit-border strobe and sampled bus bit);
//        bit_tx (driven bit, registered on bit_req); tx_valid/tx_ready with
//        tx_id/tx_dlc/tx_data (frame request); tx_done/tx_status (one report
//        per frame: OK, ARB_LOST, ACK_ERR, BIT_ERR).
// state_q/cnt_q always describe the bit currently on bit_tx. A stuff bit keeps
// the field position of the bit before it, so the successor logic is the same
// whether or not a stuff bit was just sent.
module can_frame_tx
  import can_frame_tx_pkg::*;
#(
  parameter int IDLE_BITS = 11
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        bit_req,
  input  logic        bit_rx,
  output logic        bit_tx,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [10:0] tx_id,
  input  logic [3:0]  tx_dlc,
  input  logic [63:0] tx_data,
  output logic        tx_done,
  output logic [1:0]  tx_status
);

  localparam int             IW       = $clog2(IDLE_BITS + 1);
  localparam logic [IW-1:0]  IDLE_MAX = IW'(IDLE_BITS);

  logic [2:0]    state_q, state_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [2:0]    run_q, run_d;       // length of equal-bit run ending at bit_tx
  logic          armed_q, armed_d;   // request latched, SOF goes out on next bit_req
  logic          bit_tx_q, bit_tx_d;
  logic          done_q, done_d;
  logic [1:0]    status_q, status_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [10:0]   id_q, id_d;
  logic [3:0]    dlc_q, dlc_d;
  logic [63:0]   data_q, data_d;

  logic          crc_clr, crc_en, crc_din;
  logic [14:0]   crc;
  logic          accept, stuff_zone, abort;
  logic [1:0]    abort_code;
  logic [2:0]    nstate;
  logic [6:0]    ncnt, data_last;
  logic          nbit;

  can_crc15 u_crc (
    .clk  (clk),
    .rstn (rstn),
    .clr  (crc_clr),
    .en   (crc_en),
    .din  (crc_din),
    .crc  (crc)
  );

  assign tx_ready   = (state_q == ST_IDLE) && !armed_q && (idle_cnt_q >= IDLE_MAX);
  assign accept     = tx_valid && tx_ready;
  assign stuff_zone = (state_q == ST_SOF_ARB) || (state_q == ST_CTRL_DATA) || (state_q == ST_CRC);
  assign data_last  = CTRL_HDR - 7'd1 + data_bits(dlc_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    run_d      = run_q;
    armed_d    = armed_q;
    bit_tx_d   = bit_tx_q;
    done_d     = 1'b0;
    status_d   = status_q;
    idle_cnt_d = idle_cnt_q;
    id_d       = id_q;
    dlc_d      = dlc_q;
    data_d     = data_q;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
    crc_din    = 1'b0;
    abort      = 1'b0;
    abort_code = STATUS_OK;
    nstate     = state_q;
    ncnt       = cnt_q;
    nbit       = 1'b1;

    if (bit_req) begin
      if (!bit_rx)                  idle_cnt_d = '0;
      else if (idle_cnt_q < IDLE_MAX) idle_cnt_d = idle_cnt_q + 1'b1;
    end

    if (accept) begin
      id_d    = tx_id;
      dlc_d   = tx_dlc;
      data_d  = tx_data;
      armed_d = 1'b1;
      crc_clr = 1'b1;
    end

    if (bit_req) begin
      // Step (a): judge the bit that was on the bus during this bit time.
      case (state_q)
        ST_SOF_ARB:
          if (bit_tx_q && !bit_rx) begin abort = 1'b1; abort_code = STATUS_ARB_LOST; end
        ST_CTRL_DATA, ST_CRC, ST_CRC_DEL, ST_ACK_DEL, ST_EOF:
          if (bit_rx != bit_tx_q) begin abort = 1'b1; abort_code = STATUS_BIT_ERR; end
        ST_ACK_SLOT:
          if (bit_rx) begin abort = 1'b1; abort_code = STATUS_ACK_ERR; end
        default: ;
      endcase

      // Step (b): register the next bit, unless the frame just died.
      if (abort) begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        bit_tx_d = 1'b1;
        done_d   = 1'b1;
        status_d = abort_code;
      end else if (stuff_zone && run_q == 3'd5) begin
        bit_tx_d = ~bit_tx_q;
        run_d    = 3'd1;
      end else begin
        ncnt = cnt_q + 7'd1;
        case (state_q)
          ST_IDLE: begin
            ncnt = cnt_q;
            if (armed_q) begin
              nstate  = ST_SOF_ARB;
              ncnt    = '0;
              nbit    = 1'b0;
              armed_d = 1'b0;
            end
          end
          ST_SOF_ARB:
            if (cnt_q == ARB_LAST) begin
              nstate = ST_CTRL_DATA; ncnt = '0; nbit = 1'b0;
            end else if (ncnt == ARB_LAST) nbit = 1'b0;          // RTR
            else nbit = id_q[4'(7'(ID_LEN) - ncnt)];
          ST_CTRL_DATA:
            if (cnt_q == data_last) begin
              nstate = ST_CRC; ncnt = '0; nbit = crc[CRC_LEN-1];
            end else if (ncnt < 7'd2)     nbit = 1'b0;            // IDE, r0
            else if (ncnt < CTRL_HDR)     nbit = dlc_q[2'(CTRL_HDR - 7'd1 - ncnt)];
            else                          nbit = data_q[6'(CTRL_HDR + 7'd63 - ncnt)];
          ST_CRC:
            if (cnt_q == CRC_LAST) begin
              nstate = ST_CRC_DEL; ncnt = '0;
            end else nbit = crc[4'(CRC_LAST - ncnt)];
          ST_CRC_DEL:  begin nstate = ST_ACK_SLOT; ncnt = '0; end
          ST_ACK_SLOT: begin nstate = ST_ACK_DEL;  ncnt = '0; end
          ST_ACK_DEL:  begin nstate = ST_EOF;      ncnt = '0; end
          ST_EOF:
            if (cnt_q == EOF_LAST) begin
              nstate   = ST_IDLE;
              ncnt     = '0;
              done_d   = 1'b1;
              status_d = STATUS_OK;
            end
          default: ;
        endcase
        state_d  = nstate;
        cnt_d    = ncnt;
        bit_tx_d = nbit;
        if (state_q == ST_IDLE || nbit != bit_tx_q) run_d = 3'd1;
        else if (run_q != 3'd7)                     run_d = run_q + 3'd1;
        // Only unstuffed SOF..data bits feed the CRC.
        crc_en  = (nstate == ST_SOF_ARB) || (nstate == ST_CTRL_DATA);
        crc_din = nbit;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      run_q      <= '0;
      armed_q    <= 1'b0;
      bit_tx_q   <= 1'b1;
      done_q     <= 1'b0;
      status_q   <= STATUS_OK;
      idle_cnt_q <= '0;
      id_q       <= '0;
      dlc_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
      armed_q    <= armed_d;
      bit_tx_q   <= bit_tx_d;
      done_q     <= done_d;
      status_q   <= status_d;
      idle_cnt_q <= idle_cnt_d;
      id_q       <= id_d;
      dlc_q      <= dlc_d;
      data_q     <= data_d;
    end
  end

  assign bit_tx    = bit_tx_q;
  assign tx_done   = done_q;
  assign tx_status = status_q;

endmodule

// File: tb/tb_can_frame_tx.sv
// Loopback bench for can_frame_tx: bus = bit_tx & other_node, bit_req every
// 8 clocks. Expected bus bits come from a list-based frame model (raw field
// list -> CRC over it -> stuffing pass -> delimiters/EOF).
module tb_can_frame_tx;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        bit_req = 1'b0;
  logic        bit_rx = 1'b1;
  logic        bit_tx;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [10:0] tx_id = '0;
  logic [3:0]  tx_dlc = '0;
  logic [63:0] tx_data = '0;
  logic        tx_done;
  logic [1:0]  tx_status;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int idle_m = 0;
  int ack_pos = 0;
  int raw2st [0:127];
  logic exp_q[$];
  logic got_q[$];

  can_frame_tx #(.IDLE_BITS(11)) dut (
    .clk(clk), .rstn(rstn), .bit_req(bit_req), .bit_rx(bit_rx), .bit_tx(bit_tx),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_id(tx_id), .tx_dlc(tx_dlc),
    .tx_data(tx_data), .tx_done(tx_done), .tx_status(tx_status)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  // Reference frame: bus bits from SOF to the 7th EOF bit.
  task automatic build_frame(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
    logic raw[$];
    logic [14:0] c;
    logic last;
    int nb, run;
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
    raw.push_back(1'b0); raw.push_back(1'b0); raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    nb = ((dlc > 8) ? 8 : int'(dlc)) * 8;
    for (int i = 0; i < nb; i++) raw.push_back(data[63-i]);
    c = '0;
    foreach (raw[i]) c = {c[13:0], 1'b0} ^ ((raw[i] ^ c[14]) ? 15'h4599 : 15'h0);
    for (int i = 14; i >= 0; i--) raw.push_back(c[i]);
    exp_q.delete();
    run = 0; last = 1'b1;
    foreach (raw[i]) begin
      raw2st[i] = exp_q.size();
      exp_q.push_back(raw[i]);
      run = (i > 0 && raw[i] == last) ? run + 1 : 1;
      last = raw[i];
      if (run == 5) begin exp_q.push_back(~last); last = ~last; run = 1; end
    end
    exp_q.push_back(1'b1);               // CRC delimiter
    ack_pos = exp_q.size();
    for (int i = 0; i < 9; i++) exp_q.push_back(1'b1);  // ACK slot, ACK delimiter, EOF
  endtask

  task automatic bus_bit(input logic other, output logic t, output logic d,
                         output logic [1:0] s, output logic r);
    @(negedge clk);
    bit_rx = bit_tx & other;
    bit_req = 1'b1;
    @(posedge clk); #1;
    t = bit_tx; d = tx_done; s = tx_status; r = tx_ready;
    if (bit_rx == 1'b0) idle_m = 0; else if (idle_m < 11) idle_m++;
    @(negedge clk);
    bit_req = 1'b0; bit_rx = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic handshake(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data,
                           output int waited);
    logic t, d, r; logic [1:0] s;
    waited = 0;
    while (tx_ready !== 1'b1 && waited < 40) begin bus_bit(1'b1, t, d, s, r); waited++; end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("FAIL handshake_ready: tx_ready=%b after %0d bits, required 1", tx_ready, waited);
    end
    tx_id = id; tx_dlc = dlc; tx_data = data; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    checks++;
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL ready_drop: tx_ready=%b, required 0", tx_ready); end
    build_frame(id, dlc, data);
  endtask

  // Runs a complete frame with the other node acknowledging.
  task automatic run_frame(input string name);
    logic t, d, r; logic [1:0] s;
    int n, d0;
    n = exp_q.size(); d0 = done_cnt;
    got_q.delete();
    for (int k = 0; k <= n; k++) begin
      bus_bit((k == ack_pos + 1) ? 1'b0 : 1'b1, t, d, s, r);
      if (k < n) begin
        got_q.push_back(t);
        checks++;
        if (t !== exp_q[k]) begin errors++; $display("FAIL %s bit%0d: bit_tx=%b, expected %b", name, k, t, exp_q[k]); end
        checks++;
        if (d !== 1'b0) begin errors++; $display("FAIL %s early_done bit%0d: tx_done=%b, expected 0", name, k, d); end
      end else begin
        checks++;
        if (d !== 1'b1 || s !== 2'd0) begin
          errors++; $display("FAIL %s done: tx_done=%b status=%0d, expected 1/0", name, d, s);
        end
      end
    end
    checks++;
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL %s pulses: %0d, expected 1", name, done_cnt - d0); end
  endtask

  task automatic test_reset();
    logic t, d, r; logic [1:0] s;
    rstn = 1'b0; idle_m = 0;
    #12;
    checks++;
    if (bit_tx !== 1'b1 || tx_ready !== 1'b0 || tx_done !== 1'b0 || tx_status !== 2'd0) begin
      errors++; $display("FAIL reset_vals: tx=%b rdy=%b done=%b st=%0d, expected 1/0/0/0", bit_tx, tx_ready, tx_done, tx_status);
    end
    #11 rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus_bit(1'b1, t, d, s, r);
      checks++;
      if (r !== (i + 1 >= 11)) begin errors++; $display("FAIL reset_idle bit%0d: tx_ready=%b, expected %b", i, r, (i + 1 >= 11)); end
    end
  endtask

  task automatic test_id0();
    int w;
    logic [6:0] pat, got;
    handshake(11'h000, 4'd0, 64'h0, w);
    run_frame("id0");
    pat = 7'b0000010;   // SOF + ID[10:7] zeros, stuff 1, ID[6]
    got = '1;
    for (int i = 0; i < 7 && i < got_q.size(); i++) got[6-i] = got_q[i];
    checks++;
    if (got !== pat) begin errors++; $display("FAIL id0_first_bits: %b, expected %b", got, pat); end
  endtask

  task automatic test_id7ff();
    int w;
    handshake(11'h7FF, 4'd8, 64'hFFFF_0000_AAAA_5555, w);
    run_frame("id7ff");
  endtask

  task automatic test_back_to_back();
    int w;
    for (int f = 0; f < 5; f++) begin
      handshake(11'($urandom), 4'($urandom_range(0, 15)), {$urandom, $urandom}, w);
      if (f > 0) begin
        checks++;
        if (w != 3) begin errors++; $display("FAIL rearm%0d: waited %0d bits, expected 3", f, w); end
      end
      run_frame("random");
    end
  endtask

  task automatic test_arb_lost();
    logic t, d, r; logic [1:0] s;
    int w, d0;
    handshake(11'h400, 4'd0, 64'h0, w);
    d0 = done_cnt;
    bus_bit(1'b1, t, d, s, r);
    checks++; if (t !== 1'b0) begin errors++; $display("FAIL arb_sof: bit_tx=%b, expected 0", t); end
    bus_bit(1'b1, t, d, s, r);
    checks++; if (t !== 1'b1) begin errors++; $display("FAIL arb_id10: bit_tx=%b, expected 1", t); end
    bus_bit(1'b0, t, d, s, r);
    checks++;
    if (d !== 1'b1 || s !== 2'd1 || t !== 1'b1) begin
      errors++; $display("FAIL arb_lost: done=%b st=%0d tx=%b, expected 1/1/1", d, s, t);
    end
    for (int i = 0; i < 6; i++) begin
      bus_bit(1'($urandom), t, d, s, r);
      checks++;
      if (t !== 1'b1 || r !== 1'b0) begin errors++; $display("FAIL arb_after%0d: tx=%b rdy=%b, expected 1/0", i, t, r); end
    end
    checks++;
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL arb_pulses: %0d, expected 1", done_cnt - d0); end
  endtask

  task automatic test_ack_err();
    logic t, d, r; logic [1:0] s;
    int w, a;
    handshake(11'($urandom), 4'($urandom_range(0, 8)), {$urandom, $urandom}, w);
    a = ack_pos;
    for (int k = 0; k <= a + 1; k++) begin
      bus_bit(1'b1, t, d, s, r);
      if (k <= a) begin
        checks++;
        if (t !== exp_q[k]) begin errors++; $display("FAIL ack bit%0d: bit_tx=%b, expected %b", k, t, exp_q[k]); end
      end else begin
        checks++;
        if (d !== 1'b1 || s !== 2'd2 || t !== 1'b1) begin
          errors++; $display("FAIL ack_err: done=%b st=%0d tx=%b, expected 1/2/1", d, s, t);
        end
      end
    end
    for (int i = 0; i < 14; i++) begin
      bus_bit(1'b1, t, d, s, r);
      checks++;
      if (r !== (idle_m >= 11) || t !== 1'b1) begin
        errors++; $display("FAIL ack_rearm%0d: rdy=%b tx=%b, expected %b/1", i, r, t, (idle_m >= 11));
      end
    end
  endtask

  task automatic test_bit_err();
    logic t, d, r; logic [1:0] s;
    int w, p, d0;
    handshake(11'h123, 4'd1, {$urandom, $urandom}, w);
    p = raw2st[18];     // DLC[0]
    d0 = done_cnt;
    for (int k = 0; k <= p + 1; k++) begin
      bus_bit((k == p + 1) ? 1'b0 : 1'b1, t, d, s, r);
      if (k <= p) begin
        checks++;
        if (t !== exp_q[k]) begin errors++; $display("FAIL biterr bit%0d: bit_tx=%b, expected %b", k, t, exp_q[k]); end
      end else begin
        checks++;
        if (d !== 1'b1 || s !== 2'd3 || t !== 1'b1) begin
          errors++; $display("FAIL bit_err: done=%b st=%0d tx=%b, expected 1/3/1", d, s, t);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      bus_bit(1'b1, t, d, s, r);
      checks++;
      if (t !== 1'b1) begin errors++; $display("FAIL biterr_release%0d: bit_tx=%b, expected 1", i, t); end
    end
    checks++;
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL biterr_pulses: %0d, expected 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    logic t, d, r; logic [1:0] s;
    int w, d0, n;
    logic [10:0] id2; logic [63:0] dat2;
    handshake(11'($urandom), 4'd8, {$urandom, $urandom}, w);
    for (int k = 0; k < 30; k++) bus_bit(1'b1, t, d, s, r);
    d0 = done_cnt;
    #2 rstn = 1'b0; idle_m = 0;
    #1;
    checks++;
    if (bit_tx !== 1'b1 || tx_ready !== 1'b0 || tx_done !== 1'b0) begin
      errors++; $display("FAIL midreset_vals: tx=%b rdy=%b done=%b, expected 1/0/0", bit_tx, tx_ready, tx_done);
    end
    id2 = 11'($urandom); dat2 = {$urandom, $urandom};
    tx_id = id2; tx_dlc = 4'd3; tx_data = dat2; tx_valid = 1'b1;
    #20 rstn = 1'b1;
    n = 0; r = 1'b0;
    while (r !== 1'b1 && n < 20) begin bus_bit(1'b1, t, d, s, r); n++; end
    tx_valid = 1'b0;
    checks++;
    if (n != 11) begin errors++; $display("FAIL midreset_rearm: ready after %0d bits, expected 11", n); end
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL midreset_done: %0d pulses, expected 0", done_cnt - d0); end
    build_frame(id2, 4'd3, dat2);
    run_frame("after_reset");
  endtask

  initial begin
    test_reset();
    test_id0();
    test_id7ff();
    test_back_to_back();
    test_arb_lost();
    test_ack_err();
    test_bit_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
